wbs_kdtree_slave: RTL and testbench

WBS_KDTREE_SLAVE -- requirements
Module: wbs_kdtree_slave

---
 rtl/wbs_kdtree_slave.sv | 189 ++++++++++++++++++
 tb/tb_wbs_kdtree_slave.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbs_kdtree_slave.sv
// Wishbone slave front-end for the kd-tree core: CTRL/QUERY/LEAF/BEST/NODE.
// Ports: wbs_* bus, MODE/start/status, node+leaf write, query FIFO, best read.
module wbs_kdtree_slave #(
  parameter int DATA_WIDTH = 11,
  parameter int NODE_AW    = 6,
  parameter int MEM_AW     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  load_kdtree,
  output logic                  send_best_arr,
  output logic                  fsm_start,
  input  logic                  fsm_done,
  input  logic                  fsm_busy,
  output logic                  node_wen,
  output logic [NODE_AW-1:0]    node_waddr,
  output logic [DATA_WIDTH-1:0] node_idx,
  output logic [DATA_WIDTH-1:0] node_median,
  output logic                  leaf_wen,
  output logic [MEM_AW-1:0]     leaf_waddr,
  output logic [DATA_WIDTH-1:0] leaf_wdata,
  output logic                  in_fifo_wenq,
  output logic [DATA_WIDTH-1:0] in_fifo_wdata,
  input  logic                  in_fifo_wfull_n,
  output logic                  best_ren,
  output logic [MEM_AW-1:0]     best_raddr,
  input  logic [DATA_WIDTH-1:0] best_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  localparam logic [3:0] R_CTRL  = 4'd0;
  localparam logic [3:0] R_QUERY = 4'd1;
  localparam logic [3:0] R_LEAF  = 4'd2;
  localparam logic [3:0] R_BEST  = 4'd3;
  localparam logic [3:0] R_NODE  = 4'd4;

  state_t      state;
  state_t      state_nx;
  logic        wait_best;
  logic [1:0]  mode;
  logic [31:0] debug;
  logic        done;

  logic        valid;
  logic        hit;
  logic [3:0]  region;
  logic [15:0] off;
  logic        best_rd;
  logic        query_wr;
  logic        wr;
  logic        ctrl_wr;
  logic        done_clr;
  logic [31:0] rd_val;

  logic unused_sel;
  assign unused_sel = ^wbs_sel_i;

  assign valid    = wbs_stb_i & wbs_cyc_i & (state == IDLE);
  assign hit      = (wbs_adr_i[31:20] == 12'h300);
  assign region   = wbs_adr_i[19:16];
  assign off      = wbs_adr_i[15:0];
  assign best_rd  = valid & hit & (region == R_BEST) & ~wbs_we_i;
  assign query_wr = valid & hit & (region == R_QUERY) & wbs_we_i;
  assign wr       = valid & hit & wbs_we_i;
  assign ctrl_wr  = wr & (region == R_CTRL);
  assign done_clr = ctrl_wr & (off == 16'h0008);

  assign wbs_ack_o     = (state == ACK);
  assign load_kdtree   = mode[0];
  assign send_best_arr = mode[1];

  // Read request goes out in the decode cycle so the word is back in WAIT.
  assign best_ren   = rst_n & best_rd;
  assign best_raddr = best_ren ? off[MEM_AW-1:0] : '0;

  assign in_fifo_wenq = (state == WAIT) & ~wait_best & in_fifo_wfull_n;

  always_comb begin
    rd_val = 32'h0;
    if (hit && region == R_CTRL) begin
      case (off)
        16'h0000: rd_val = {30'h0, mode};
        16'h0004: rd_val = debug;
        16'h0008: rd_val = {31'h0, done};
        16'h0010: rd_val = {31'h0, fsm_busy};
        default:  rd_val = 32'h0;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (valid) begin
          state_nx = (best_rd | query_wr) ? WAIT : ACK;
        end
      end
      WAIT: begin
        if (wait_best || in_fifo_wfull_n) begin
          state_nx = ACK;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wait_best     <= 1'b0;
      wbs_dat_o     <= 32'h0;
      mode          <= 2'b0;
      debug         <= 32'h0;
      done          <= 1'b0;
      fsm_start     <= 1'b0;
      node_wen      <= 1'b0;
      node_waddr    <= '0;
      node_idx      <= '0;
      node_median   <= '0;
      leaf_wen      <= 1'b0;
      leaf_waddr    <= '0;
      leaf_wdata    <= '0;
      in_fifo_wdata <= '0;
    end else begin
      state     <= state_nx;
      wbs_dat_o <= 32'h0;
      fsm_start <= 1'b0;
      node_wen  <= 1'b0;
      leaf_wen  <= 1'b0;

      if (best_rd || query_wr) begin
        wait_best <= best_rd;
      end
      if (query_wr) begin
        in_fifo_wdata <= wbs_dat_i[DATA_WIDTH-1:0];
      end

      if (valid && !wbs_we_i && !best_rd) begin
        wbs_dat_o <= rd_val;
      end
      if (state == WAIT && wait_best) begin
        wbs_dat_o <= {{(32-DATA_WIDTH){1'b0}}, best_rdata};
      end

      if (ctrl_wr) begin
        case (off)
          16'h0000: mode      <= wbs_dat_i[1:0];
          16'h0004: debug     <= wbs_dat_i;
          16'h000C: fsm_start <= 1'b1;
          default:  ;
        endcase
      end
      if (wr && region == R_LEAF) begin
        leaf_wen   <= 1'b1;
        leaf_waddr <= off[MEM_AW-1:0];
        leaf_wdata <= wbs_dat_i[DATA_WIDTH-1:0];
      end
      if (wr && region == R_NODE) begin
        node_wen    <= 1'b1;
        node_waddr  <= off[NODE_AW-1:0];
        node_idx    <= wbs_dat_i[DATA_WIDTH-1:0];
        node_median <= wbs_dat_i[2*DATA_WIDTH-1:DATA_WIDTH];
      end

      // A completion from the core beats a simultaneous software clear.
      if (fsm_done) begin
        done <= 1'b1;
      end else if (done_clr) begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wbs_kdtree_slave.sv
// Randomized scoreboard bench for wbs_kdtree_slave.
// Driver pushes expectations; negedge monitor pops on ack and side-effect pulses.
module tb_wbs_kdtree_slave;
  localparam int DW  = 11;
  localparam int NAW = 6;
  localparam int MAW = 12;

  logic clk = 0;
  logic rst_n = 0;
  logic stb = 0, cyc = 0, we = 0;
  logic [3:0] sel = 4'hF;
  logic [31:0] adr = 0, wdat = 0;
  logic ack;
  logic [31:0] rdat;
  logic load_kdtree, send_best_arr, fsm_start;
  logic fsm_done = 0, fsm_busy = 0;
  logic node_wen;
  logic [NAW-1:0] node_waddr;
  logic [DW-1:0] node_idx, node_median;
  logic leaf_wen;
  logic [MAW-1:0] leaf_waddr;
  logic [DW-1:0] leaf_wdata;
  logic in_fifo_wenq;
  logic [DW-1:0] in_fifo_wdata;
  logic in_fifo_wfull_n = 1;
  logic best_ren;
  logic [MAW-1:0] best_raddr;
  logic [DW-1:0] best_rdata = 0;

  always #5 clk = ~clk;

  wbs_kdtree_slave #(.DATA_WIDTH(DW), .NODE_AW(NAW), .MEM_AW(MAW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat),
    .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .load_kdtree(load_kdtree), .send_best_arr(send_best_arr),
    .fsm_start(fsm_start), .fsm_done(fsm_done), .fsm_busy(fsm_busy),
    .node_wen(node_wen), .node_waddr(node_waddr),
    .node_idx(node_idx), .node_median(node_median),
    .leaf_wen(leaf_wen), .leaf_waddr(leaf_waddr), .leaf_wdata(leaf_wdata),
    .in_fifo_wenq(in_fifo_wenq), .in_fifo_wdata(in_fifo_wdata),
    .in_fifo_wfull_n(in_fifo_wfull_n),
    .best_ren(best_ren), .best_raddr(best_raddr), .best_rdata(best_rdata)
  );

  logic [DW-1:0] bmem [0:(1<<MAW)-1];
  always @(posedge clk) if (best_ren) best_rdata <= bmem[best_raddr];

  int checks = 0;
  int errors = 0;

  logic [32:0] sb_q[$];
  logic [31:0] node_q[$];
  logic [31:0] leaf_q[$];
  logic [DW-1:0] enq_q[$];
  logic [MAW-1:0] best_q[$];
  int start_cnt = 0;

  logic [1:0] m_mode = 0;
  logic [31:0] m_debug = 0;
  logic m_done = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [32:0] e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ack) begin
        if (sb_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          e = sb_q.pop_front();
          if (e[32]) chk("ack_rdata", rdat, e[31:0]);
        end
      end else begin
        chk("rdata_idle_zero", rdat, 0);
      end
      if (node_wen) begin
        if (node_q.size() == 0) chk("unexpected_node_wen", 1, 0);
        else chk("node_write", {4'h0, node_waddr, node_median, node_idx},
                 node_q.pop_front());
      end
      if (leaf_wen) begin
        if (leaf_q.size() == 0) chk("unexpected_leaf_wen", 1, 0);
        else chk("leaf_write", {9'h0, leaf_waddr, leaf_wdata},
                 leaf_q.pop_front());
      end
      if (in_fifo_wenq) begin
        chk("enq_while_full", {31'h0, in_fifo_wfull_n}, 1);
        if (enq_q.size() == 0) chk("unexpected_enq", 1, 0);
        else chk("enq_data", {21'h0, in_fifo_wdata},
                 {21'h0, enq_q.pop_front()});
      end
      if (best_ren) begin
        if (best_q.size() == 0) chk("unexpected_best_ren", 1, 0);
        else chk("best_raddr", {20'h0, best_raddr},
                 {20'h0, best_q.pop_front()});
      end
      if (fsm_start) begin
        if (start_cnt == 0) chk("unexpected_fsm_start", 1, 0);
        else start_cnt--;
      end
    end
  end

  task automatic txn(input logic w, input logic [31:0] a,
                     input logic [31:0] d, input int stall);
    logic [32:0] x;
    logic hit;
    logic [3:0] rg;
    logic [15:0] off;
    int lat, exp_lat;
    logic got;
    hit = (a[31:20] == 12'h300);
    rg = a[19:16];
    off = a[15:0];
    exp_lat = 1;
    x = {~w, 32'h0};
    if (hit && rg == 0 && !w) begin
      case (off)
        16'h0000: x[31:0] = {30'h0, m_mode};
        16'h0004: x[31:0] = m_debug;
        16'h0008: x[31:0] = {31'h0, m_done};
        16'h0010: x[31:0] = {31'h0, fsm_busy};
        default:  x[31:0] = 0;
      endcase
    end
    if (hit && rg == 3 && !w) begin
      x[31:0] = {21'h0, bmem[off[MAW-1:0]]};
      exp_lat = 2;
      best_q.push_back(off[MAW-1:0]);
    end
    if (hit && rg == 1 && w) begin
      exp_lat = stall + 2;
      enq_q.push_back(d[DW-1:0]);
    end
    if (hit && rg == 2 && w) leaf_q.push_back({9'h0, off[MAW-1:0], d[DW-1:0]});
    if (hit && rg == 4 && w) node_q.push_back({4'h0, off[NAW-1:0], d[21:11], d[10:0]});
    if (hit && rg == 0 && w && off == 16'h000C) start_cnt++;
    sb_q.push_back(x);
    in_fifo_wfull_n = !(hit && rg == 1 && w && stall > 0);
    stb = 1; cyc = 1; we = w; adr = a; wdat = d;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat >= stall + 1) in_fifo_wfull_n = 1;
      @(negedge clk);
      got = ack;
    end
    chk("ack_latency", lat, exp_lat);
    if (hit && rg == 0 && w) begin
      case (off)
        16'h0000: m_mode = d[1:0];
        16'h0004: m_debug = d;
        16'h0008: m_done = fsm_done;
        default: ;
      endcase
    end
    chk("mode_out", {30'h0, send_best_arr, load_kdtree}, {30'h0, m_mode});
    @(posedge clk); #1;
    stb = 0; cyc = 0; we = 0;
    chk("ack_single_cycle", {31'h0, ack}, 0);
  endtask

  task automatic pulse_done();
    @(posedge clk); #1 fsm_done = 1;
    @(posedge clk); #1 fsm_done = 0;
    m_done = 1;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_ack"}, {31'h0, ack}, 0);
    chk({tag, "_rdata"}, rdat, 0);
    chk({tag, "_pulses"},
        {26'h0, in_fifo_wenq, best_ren, node_wen, leaf_wen, fsm_start, 1'b0}, 0);
    chk({tag, "_mode"}, {30'h0, send_best_arr, load_kdtree}, 0);
    chk({tag, "_node"}, {4'h0, node_waddr, node_median, node_idx}, 0);
    chk({tag, "_leaf"}, {9'h0, leaf_waddr, leaf_wdata}, 0);
    chk({tag, "_addr"}, {9'h0, best_raddr, in_fifo_wdata}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] a, d;
  logic [15:0] ctrl_offs [0:4];
  int k;

  initial begin
    for (int i = 0; i < (1 << MAW); i++) bmem[i] = DW'($urandom);
    ctrl_offs[0] = 16'h0000; ctrl_offs[1] = 16'h0004; ctrl_offs[2] = 16'h0008;
    ctrl_offs[3] = 16'h000C; ctrl_offs[4] = 16'h0010;

    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1;
    @(posedge clk); #1;

    txn(1, 32'h3000_0004, 32'hDEADBEEF, 0);
    txn(0, 32'h3000_0004, 0, 0);
    txn(1, 32'h3004_0005, {10'b0, 11'd55, 11'd1}, 0);
    txn(1, 32'h3001_0000, 32'h0000_0123, 4);
    bmem[7] = 11'h2A;
    txn(0, 32'h3003_0007, 0, 0);
    pulse_done();
    txn(0, 32'h3000_0008, 0, 0);
    txn(1, 32'h3000_0008, 0, 0);
    txn(0, 32'h3000_0008, 0, 0);
    txn(1, 32'h3000_000C, 32'h1, 0);
    txn(0, 32'h3000_000C, 0, 0);
    fsm_done = 1;
    txn(1, 32'h3000_0008, 0, 0);
    #1 fsm_done = 0;
    m_done = 1;
    txn(0, 32'h3000_0008, 0, 0);
    txn(1, 32'h3000_0000, 32'h3, 0);
    txn(0, 32'h3000_0000, 0, 0);
    fsm_busy = 1;
    txn(0, 32'h3000_0010, 0, 0);
    txn(1, 32'h3000_0010, 32'h0, 0);
    txn(1, 32'h3003_0007, 32'h55, 0);
    txn(0, 32'h3005_0000, 0, 0);
    txn(0, 32'h4000_0000, 0, 0);

    for (int i = 0; i < 300; i++) begin
      fsm_busy = 1'($urandom);
      if ($urandom_range(0, 7) == 0) pulse_done();
      k = $urandom_range(0, 7);
      d = $urandom;
      case (k)
        0: txn(1, {16'h3000, ctrl_offs[$urandom_range(0, 4)]}, d, 0);
        1: begin
          a = {16'h3000, ctrl_offs[$urandom_range(0, 4)]};
          if ($urandom_range(0, 3) == 0) a[15:0] = 16'($urandom);
          txn(0, a, 0, 0);
        end
        2: txn(1, {16'h3001, 16'($urandom)}, d, $urandom_range(0, 3));
        3: txn(1, {16'h3002, 16'($urandom)}, d, 0);
        4: txn(0, {16'h3003, 16'($urandom)}, 0, 0);
        5: txn(1, {16'h3004, 16'($urandom)}, d, 0);
        6: begin
          a = $urandom;
          if (a[31:20] == 12'h300) a[19:16] = 4'($urandom_range(5, 15));
          txn(1'($urandom), a, d, 0);
        end
        default: begin
          a = {16'h3000, 16'($urandom)};
          a[19:16] = ($urandom_range(0, 2) == 0) ? 4'd1 :
                     ($urandom_range(0, 1) == 0) ? 4'd2 : 4'd4;
          if ($urandom_range(0, 3) == 0) txn(1, {16'h3003, a[15:0]}, d, 0);
          else txn(0, a, 0, 0);
        end
      endcase
    end

    @(posedge clk); #1;
    in_fifo_wfull_n = 0;
    stb = 1; cyc = 1; we = 1; adr = 32'h3001_0000; wdat = 32'h5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check_zero_outputs("reset_in_wait");
    stb = 0; cyc = 0; we = 0;
    m_mode = 0; m_debug = 0; m_done = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    in_fifo_wfull_n = 1;
    repeat (4) begin
      @(negedge clk);
      chk("no_ack_after_reset", {31'h0, ack}, 0);
    end
    @(posedge clk); #1;
    txn(0, 32'h3000_0004, 0, 0);

    repeat (3) @(posedge clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("node_drained", node_q.size(), 0);
    chk("leaf_drained", leaf_q.size(), 0);
    chk("enq_drained", enq_q.size(), 0);
    chk("best_drained", best_q.size(), 0);
    chk("start_drained", start_cnt, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
